// File: rtl/axi_node_pkg.sv
// Shared AXI node definitions: response encodings, DECERR FSM states and a counter-width helper.
package axi_node_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } decerr_state_e;

    // Bits needed to count 0..max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/axi_address_decoder.sv
// Combinational address-range match against the master-port map; lowest enabled index wins.
module axi_address_decoder #(
    parameter int unsigned AXI_ADDRESS_W = 32,
    parameter int unsigned N_INIT_PORT   = 8
) (
    input  logic [AXI_ADDRESS_W-1:0]                  i_addr,
    input  logic [N_INIT_PORT-1:0][AXI_ADDRESS_W-1:0] i_start_addr,
    input  logic [N_INIT_PORT-1:0][AXI_ADDRESS_W-1:0] i_end_addr,
    input  logic [N_INIT_PORT-1:0]                    i_enable_region,
    output logic [N_INIT_PORT-1:0]                    o_match,
    output logic                                      o_valid
);

    always_comb begin
        o_match = '0;
        o_valid = 1'b0;
        for (int p = 0; p < N_INIT_PORT; p++) begin
            if (!o_valid && i_enable_region[p] &&
                (i_addr >= i_start_addr[p]) && (i_addr <= i_end_addr[p])) begin
                o_match[p] = 1'b1;
                o_valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_ar_request_decoder.sv
// Per-slave-port AR decoder with single-destination ordering; define AXI_AR_DECERR_EN to build
// the internal DECERR responder for unmapped requests (otherwise they route to the last port).
module axi_ar_request_decoder
    import axi_node_pkg::*;
#(
    parameter int unsigned AXI_ADDRESS_W   = 32,
    parameter int unsigned AXI_ID_IN       = 16,
    parameter int unsigned N_INIT_PORT     = 8,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned CNT_W           = cnt_width(MAX_OUTSTANDING)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [AXI_ID_IN-1:0]                      arid_i,
    input  logic [AXI_ADDRESS_W-1:0]                  araddr_i,
    input  logic [7:0]                                arlen_i,
    input  logic                                      arvalid_i,
    output logic                                      arready_o,
    output logic [N_INIT_PORT-1:0]                    arvalid_o,
    input  logic [N_INIT_PORT-1:0]                    arready_i,
    input  logic [N_INIT_PORT-1:0][AXI_ADDRESS_W-1:0] start_addr_i,
    input  logic [N_INIT_PORT-1:0][AXI_ADDRESS_W-1:0] end_addr_i,
    input  logic [N_INIT_PORT-1:0]                    enable_region_i,
    input  logic                                      r_done_i,
    output logic [AXI_ID_IN-1:0]                      err_rid_o,
    output logic [1:0]                                err_rresp_o,
    output logic                                      err_rlast_o,
    output logic                                      err_rvalid_o,
    input  logic                                      err_rready_i
);

    localparam int unsigned      IDX_W   = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [N_INIT_PORT-1:0] w_match;
    logic                   w_hit;
    logic [IDX_W-1:0]       w_port;
    logic [IDX_W-1:0]       w_tgt;
    logic                   w_mapped;
    logic                   w_idle;
    logic                   w_wait_acc;
    logic                   w_allow;
    logic                   w_inc;
    logic                   w_dec;

    logic [IDX_W-1:0]       r_dest;
    logic [CNT_W-1:0]       r_cnt;

    axi_address_decoder #(
        .AXI_ADDRESS_W (AXI_ADDRESS_W),
        .N_INIT_PORT   (N_INIT_PORT)
    ) u_addr_dec (
        .i_addr          (araddr_i),
        .i_start_addr    (start_addr_i),
        .i_end_addr      (end_addr_i),
        .i_enable_region (enable_region_i),
        .o_match         (w_match),
        .o_valid         (w_hit)
    );

    always_comb begin
        w_port = '0;
        for (int p = 0; p < N_INIT_PORT; p++) begin
            if (w_match[p]) w_port = IDX_W'(p);
        end
    end

`ifdef AXI_AR_DECERR_EN
    decerr_state_e        r_state;
    logic [7:0]           r_beat;
    logic [AXI_ID_IN-1:0] r_rid;
    logic                 r_rvalid;
    logic                 r_rlast;

    assign w_mapped   = w_hit;
    assign w_tgt      = w_port;
    assign w_idle     = (r_state == StIdle);
    assign w_wait_acc = (r_state == StWait) && (r_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_beat   <= '0;
            r_rid    <= '0;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (arvalid_i && !w_hit) r_state <= StWait;
                end
                StWait: begin
                    // Hold off until every earlier read has returned so DECERR stays in order.
                    if (r_cnt == '0) begin
                        r_rid    <= arid_i;
                        r_beat   <= arlen_i;
                        r_rvalid <= 1'b1;
                        r_rlast  <= (arlen_i == 8'd0);
                        r_state  <= StResp;
                    end
                end
                StResp: begin
                    if (err_rready_i) begin
                        if (r_beat == 8'd0) begin
                            r_rvalid <= 1'b0;
                            r_rlast  <= 1'b0;
                            r_state  <= StIdle;
                        end else begin
                            r_beat  <= r_beat - 8'd1;
                            r_rlast <= (r_beat == 8'd1);
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign err_rid_o    = r_rid;
    assign err_rvalid_o = r_rvalid;
    assign err_rlast_o  = r_rlast;
`else
    logic w_unused;
    assign w_unused = ^{err_rready_i, arid_i, arlen_i};

    assign w_mapped     = 1'b1;
    assign w_tgt        = w_hit ? w_port : IDX_W'(N_INIT_PORT - 1);
    assign w_idle       = 1'b1;
    assign w_wait_acc   = 1'b0;
    assign err_rid_o    = '0;
    assign err_rvalid_o = 1'b0;
    assign err_rlast_o  = 1'b0;
`endif

    assign err_rresp_o = RESP_DECERR;

    assign w_allow = w_idle && w_mapped && (r_cnt < MAX_CNT) &&
                     ((r_cnt == '0) || (w_tgt == r_dest));

    always_comb begin
        arvalid_o = '0;
        for (int p = 0; p < N_INIT_PORT; p++) begin
            arvalid_o[p] = w_allow && arvalid_i && (w_tgt == IDX_W'(p));
        end
    end

    assign arready_o = (w_allow && arready_i[w_tgt]) || w_wait_acc;
    assign w_inc     = arvalid_i && w_allow && arready_i[w_tgt];
    assign w_dec     = r_done_i && (r_cnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_dest <= '0;
        end else begin
            if (w_inc) r_dest <= w_tgt;
            if (w_inc && !w_dec) r_cnt <= r_cnt + 1'b1;
            else if (w_dec && !w_inc) r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_ar_request_decoder.sv
// Directed scoreboard bench for axi_ar_request_decoder; covers both AXI_AR_DECERR_EN builds.
module tb_axi_ar_request_decoder;
    import axi_node_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [15:0]      arid_i;
    logic [31:0]      araddr_i;
    logic [7:0]       arlen_i;
    logic             arvalid_i;
    logic             arready_o;
    logic [7:0]       arvalid_o;
    logic [7:0]       arready_i;
    logic [7:0][31:0] start_addr_i;
    logic [7:0][31:0] end_addr_i;
    logic [7:0]       enable_region_i;
    logic             r_done_i;
    logic [15:0]      err_rid_o;
    logic [1:0]       err_rresp_o;
    logic             err_rlast_o;
    logic             err_rvalid_o;
    logic             err_rready_i;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0]  exp_port[$];
    logic [18:0] exp_beat[$];

    axi_ar_request_decoder dut (
        .clk             (clk),
        .rst             (rst),
        .arid_i          (arid_i),
        .araddr_i        (araddr_i),
        .arlen_i         (arlen_i),
        .arvalid_i       (arvalid_i),
        .arready_o       (arready_o),
        .arvalid_o       (arvalid_o),
        .arready_i       (arready_i),
        .start_addr_i    (start_addr_i),
        .end_addr_i      (end_addr_i),
        .enable_region_i (enable_region_i),
        .r_done_i        (r_done_i),
        .err_rid_o       (err_rid_o),
        .err_rresp_o     (err_rresp_o),
        .err_rlast_o     (err_rlast_o),
        .err_rvalid_o    (err_rvalid_o),
        .err_rready_i    (err_rready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every AR acceptance and every DECERR beat is popped and compared here.
    always @(negedge clk) begin
        if (!rst && arvalid_i && arready_o) begin
            if (exp_port.size() == 0) chk("accept_unexpected", 64'(arvalid_o), 64'hFFFF);
            else chk("accept_port", 64'(arvalid_o), 64'(exp_port.pop_front()));
        end
        if (!rst && err_rvalid_o && err_rready_i) begin
            if (exp_beat.size() == 0) chk("beat_unexpected", 64'(err_rid_o), 64'hFFFF);
            else chk("beat", 64'({err_rid_o, err_rresp_o, err_rlast_o}),
                     64'(exp_beat.pop_front()));
        end
    end

    task automatic req(input logic [31:0] addr, input logic [15:0] id, input logic [7:0] len,
                       input logic [7:0] exp);
        exp_port.push_back(exp);
        araddr_i  = addr;
        arid_i    = id;
        arlen_i   = len;
        arvalid_i = 1'b1;
    endtask

    task automatic wait_accept(input string tag);
        int n = 0;
        @(negedge clk);
        while (!arready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, 64'(arready_o), 64'd1);
        @(posedge clk);
        #1 arvalid_i = 1'b0;
    endtask

    task automatic drain(input int n);
        r_done_i = 1'b1;
        repeat (n) @(posedge clk);
        #1 r_done_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; arid_i = '0; araddr_i = '0; arlen_i = '0; arvalid_i = 1'b0;
        arready_i = '0; r_done_i = 1'b0; err_rready_i = 1'b0;
        start_addr_i = '0; end_addr_i = '0;
        start_addr_i[0] = 32'h0000_0000; end_addr_i[0] = 32'h0FFF_FFFF;
        start_addr_i[1] = 32'h1000_0000; end_addr_i[1] = 32'h1FFF_FFFF;
        start_addr_i[2] = 32'h4000_0000; end_addr_i[2] = 32'h4FFF_FFFF;
        start_addr_i[5] = 32'h3000_0000; end_addr_i[5] = 32'h5FFF_FFFF;
        enable_region_i = 8'b0010_0111;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_arready", arready_o, 0);
        chk("rst_arvalid", arvalid_o, 0);
        chk("rst_err_rvalid", err_rvalid_o, 0);
        chk("rst_err_rlast", err_rlast_o, 0);
        chk("rst_err_rid", err_rid_o, 0);
        chk("rst_err_rresp", err_rresp_o, 2'b11);
        chk("rst_cnt", dut.r_cnt, 0);
        chk("rst_dest", dut.r_dest, 0);
        rst = 1'b0;
        arready_i = 8'hFF;

        // Basic decode with same-cycle accept.
        @(posedge clk); #1;
        req(32'h1000_0004, 16'h1, 8'd0, 8'b0000_0010);
        @(negedge clk);
        chk("t1_arvalid", arvalid_o, 8'b0000_0010);
        chk("t1_arready", arready_o, 1);
        @(posedge clk); #1 arvalid_i = 1'b0;
        chk("t1_cnt", dut.r_cnt, 1);

        // Different destination stalls until the outstanding read completes.
        req(32'h0000_0100, 16'h2, 8'd0, 8'b0000_0001);
        repeat (3) begin
            @(negedge clk);
            chk("t2_stall_arvalid", arvalid_o, 0);
            chk("t2_stall_arready", arready_o, 0);
        end
        @(posedge clk); #1 r_done_i = 1'b1;
        @(posedge clk); #1 r_done_i = 1'b0;
        @(negedge clk);
        chk("t2_accept_at_zero", arready_o, 1);
        chk("t2_arvalid", arvalid_o, 8'b0000_0001);
        @(posedge clk); #1 arvalid_i = 1'b0;
        chk("t2_cnt", dut.r_cnt, 1);
        drain(1);

        // Fill to MAX_OUTSTANDING, stall, then simultaneous increment/decrement.
        for (int i = 0; i < 8; i++) begin
            req(32'h1000_0000 + 32'(i * 64), 16'(i), 8'd0, 8'b0000_0010);
            wait_accept("t3_fill");
        end
        chk("t3_cnt_full", dut.r_cnt, 8);
        req(32'h1000_1000, 16'h9, 8'd0, 8'b0000_0010);
        repeat (2) begin
            @(negedge clk);
            chk("t3_ninth_stall", arvalid_o, 0);
        end
        @(posedge clk); #1 r_done_i = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_ninth_accept", arready_o, 1);
        @(posedge clk); #1 r_done_i = 1'b0; arvalid_i = 1'b0;
        chk("t3_inc_dec_same", dut.r_cnt, 7);
        req(32'h1000_2000, 16'hA, 8'd0, 8'b0000_0010);
        wait_accept("t3_refill");
        chk("t3_cnt_refill", dut.r_cnt, 8);
        drain(9);
        chk("t3_no_underflow", dut.r_cnt, 0);

        // Overlapping regions: lowest enabled index wins.
        req(32'h4000_0000, 16'hB, 8'd0, 8'b0000_0100);
        wait_accept("t4_overlap");
        drain(1);
        enable_region_i = 8'b0010_0011;
        req(32'h4000_0000, 16'hC, 8'd0, 8'b0010_0000);
        wait_accept("t4_disabled");
        drain(1);
        enable_region_i = 8'b0010_0111;

        // arvalid_o raised without a grant and held until it comes.
        arready_i = 8'h00;
        req(32'h1000_0000, 16'hD, 8'd0, 8'b0000_0010);
        repeat (2) begin
            @(negedge clk);
            chk("t5_arvalid_no_grant", arvalid_o, 8'b0000_0010);
            chk("t5_arready_no_grant", arready_o, 0);
        end
        @(posedge clk); #1 arready_i = 8'hFF;
        wait_accept("t5_grant");
        chk("t5_cnt", dut.r_cnt, 1);

        // Reset with reads in flight clears the counter at once.
        rst = 1'b1;
        #1 chk("t6_rst_cnt", dut.r_cnt, 0);
        @(posedge clk); #1 rst = 1'b0;

`ifdef AXI_AR_DECERR_EN
        for (int i = 0; i < 2; i++) begin
            req(32'h1000_0000, 16'(i), 8'd0, 8'b0000_0010);
            wait_accept("t7_pre");
        end
        for (int i = 0; i < 4; i++) exp_beat.push_back({16'h003A, 2'b11, (i == 3)});
        req(32'hF000_0000, 16'h003A, 8'd3, 8'h00);
        repeat (3) begin
            @(negedge clk);
            chk("t7_decerr_stall", arready_o, 0);
            chk("t7_decerr_no_route", arvalid_o, 0);
        end
        drain(2);
        wait_accept("t7_decerr");
        chk("t7_first_beat", err_rvalid_o, 1);
        begin
            int guard = 0;
            while (exp_beat.size() > 0 && guard < 200) begin
                err_rready_i = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                guard++;
            end
            chk("t7_beats_done", exp_beat.size(), 0);
        end
        err_rready_i = 1'b0;
        @(negedge clk);
        chk("t7_rvalid_low", err_rvalid_o, 0);
        chk("t7_state_idle", dut.r_state, StIdle);

        // Reset during beat 2.
        exp_beat.push_back({16'h0055, 2'b11, 1'b0});
        req(32'hF000_0000, 16'h0055, 8'd3, 8'h00);
        wait_accept("t8_decerr");
        err_rready_i = 1'b1;
        @(posedge clk); #1 err_rready_i = 1'b0;
        chk("t8_beat2_valid", err_rvalid_o, 1);
        rst = 1'b1;
        #1;
        chk("t8_rst_rvalid", err_rvalid_o, 0);
        chk("t8_rst_state", dut.r_state, StIdle);
        chk("t8_rst_cnt", dut.r_cnt, 0);
        chk("t8_beats_done", exp_beat.size(), 0);
        @(posedge clk); #1 rst = 1'b0;
`else
        // Unmapped requests fall through to the last port.
        req(32'hF000_0000, 16'h003A, 8'd3, 8'b1000_0000);
        wait_accept("t7_unmapped");
        chk("t7_cnt", dut.r_cnt, 1);
        req(32'h1000_0000, 16'h1, 8'd0, 8'b0000_0010);
        @(negedge clk);
        chk("t7_order_stall", arvalid_o, 0);
        drain(1);
        wait_accept("t7_after");
        chk("t7_err_rvalid", err_rvalid_o, 0);
        chk("t7_err_rlast", err_rlast_o, 0);
        chk("t7_err_rid", err_rid_o, 0);
        drain(1);
`endif

        @(posedge clk); #1;
        chk("end_port_sb_empty", exp_port.size(), 0);
        chk("end_beat_sb_empty", exp_beat.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
